countdown_timer: RTL and testbench

Loadable down-counter that runs the up-counter idea in reverse. It takes a start value from the Vbuddy rotary encoder (`vbdValue`), decrements it once per `PRESCALE` enabled clock cycles, and flags terminal count with a one-cycle pulse. It sits beside the up-counter in the lab datapath and drives the Vbuddy display and flag LED through `count` and `tc`.

---
 rtl/countdown_timer_if.sv | 15 +
 rtl/countdown_timer.sv | 76 +++++++
 tb/tb_countdown_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the lab datapath and countdown_timer.
// The datapath drives en/load/vbdValue and observes count/busy/tc.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] vbdValue;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             tc;

    modport master (output en, load, vbdValue, input  count, busy, tc);
    modport slave  (input  en, load, vbdValue, output count, busy, tc);
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler and a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTORELOAD_EN to restart from the loaded value at terminal count.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic               clk,
    input  logic               rst,
    countdown_timer_if.slave   bus
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             busy_q;
    logic             tc_q, tc_d;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pre_d    = pre_q;
        tc_d     = 1'b0;
        if (bus.load) begin
            // Load beats any decrement on the same edge, so no tc here.
            count_d  = bus.vbdValue;
            reload_d = bus.vbdValue;
            pre_d    = '0;
            state_d  = (bus.vbdValue != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.en) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else begin
                    tc_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                    count_d = reload_q;
`else
                    count_d = '0;
                    state_d = DONE;
`endif
                end
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pre_q    <= '0;
            busy_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pre_q    <= pre_d;
            busy_q   <= (state_d == RUN);
            tc_q     <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = busy_q;
    assign bus.tc    = tc_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: two timers (PRESCALE 1 and 4) driven by directed vectors,
// expected outputs queued per clock and checked by a negedge monitor.
module tb_countdown_timer;
`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk;
    logic rstA, rstB;

    countdown_timer_if #(.WIDTH(8)) ifA ();
    countdown_timer_if #(.WIDTH(8)) ifB ();

    countdown_timer #(.WIDTH(8), .PRESCALE(1)) dutA (.clk(clk), .rst(rstA), .bus(ifA));
    countdown_timer #(.WIDTH(8), .PRESCALE(4)) dutB (.clk(clk), .rst(rstB), .bus(ifB));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sel;
        logic [7:0] cnt;
        logic       busy;
        logic       tc;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    exp_t       m_e;
    logic [7:0] m_c;
    logic       m_b, m_t;

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            m_c = m_e.sel ? ifB.count : ifA.count;
            m_b = m_e.sel ? ifB.busy  : ifA.busy;
            m_t = m_e.sel ? ifB.tc    : ifA.tc;
            n_vec++;
            if (m_c !== m_e.cnt || m_b !== m_e.busy || m_t !== m_e.tc) begin
                n_err++;
                $display("FAIL %s: got count=%0d busy=%b tc=%b, want count=%0d busy=%b tc=%b",
                         m_e.tag, m_c, m_b, m_t, m_e.cnt, m_e.busy, m_e.tc);
            end
        end
    end

    // One clock of stimulus on the selected DUT; the other DUT holds.
    task automatic cyc(input bit s, input bit r, input bit e, input bit l,
                       input logic [7:0] v, input logic [7:0] ec,
                       input logic eb, input logic et, input string tag);
        @(negedge clk);
        #1;
        if (s) begin
            rstB = r; ifB.en = e; ifB.load = l; ifB.vbdValue = v;
            rstA = 1'b0; ifA.en = 1'b0; ifA.load = 1'b0;
        end else begin
            rstA = r; ifA.en = e; ifA.load = l; ifA.vbdValue = v;
            rstB = 1'b0; ifB.en = 1'b0; ifB.load = 1'b0;
        end
        sb.push_back('{sel: s, cnt: ec, busy: eb, tc: et, tag: tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rstA = 1'b0; rstB = 1'b0;
        ifA.en = 1'b0; ifA.load = 1'b0; ifA.vbdValue = '0;
        ifB.en = 1'b0; ifB.load = 1'b0; ifB.vbdValue = '0;

        // Reset with a competing load: reset must win.
        cyc(0, 1, 0, 1, 8'h55, 8'd0, 0, 0, "rstA_0");
        cyc(0, 1, 0, 1, 8'h55, 8'd0, 0, 0, "rstA_1");
        cyc(1, 1, 0, 1, 8'h55, 8'd0, 0, 0, "rstB_0");
        cyc(1, 1, 0, 1, 8'h55, 8'd0, 0, 0, "rstB_1");
        cyc(0, 0, 1, 0, 8'h00, 8'd0, 0, 0, "idle_ignores_en");

`ifndef COUNTDOWN_AUTORELOAD_EN
        cyc(0, 0, 1, 1, 8'd3, 8'd3, 1, 0, "os_load3");
        cyc(0, 0, 1, 0, 8'd0, 8'd2, 1, 0, "os_cnt2");
        cyc(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, "os_cnt1");
        cyc(0, 0, 1, 0, 8'd0, 8'd0, 0, 1, "os_tc");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, "os_done_hold");
`else
        cyc(0, 0, 1, 1, 8'd2, 8'd2, 1, 0, "ar_load2");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, "ar_cnt1");
            cyc(0, 0, 1, 0, 8'd0, 8'd2, 1, 1, "ar_reload_tc");
        end
`endif

        cyc(0, 0, 1, 1, 8'd0, 8'd0, 0, 0, "zero_load");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, "zero_idle");

        // Load lands on the edge that would be the terminal decrement.
        cyc(0, 0, 1, 1, 8'd2, 8'd2, 1, 0, "pri_load2");
        cyc(0, 0, 1, 0, 8'd0, 8'd1, 1, 0, "pri_cnt1");
        cyc(0, 0, 1, 1, 8'd5, 8'd5, 1, 0, "pri_load5");
        cyc(0, 0, 1, 0, 8'd0, 8'd4, 1, 0, "pri_cnt4");
        cyc(0, 0, 1, 0, 8'd0, 8'd3, 1, 0, "pri_cnt3");

        // PRESCALE=4 with a 3-cycle pause after two enabled cycles.
        cyc(1, 0, 1, 1, 8'd2, 8'd2, 1, 0, "ps_load2");
        cyc(1, 0, 1, 0, 8'd0, 8'd2, 1, 0, "ps_en1");
        cyc(1, 0, 1, 0, 8'd0, 8'd2, 1, 0, "ps_en2");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 0, 0, 8'd0, 8'd2, 1, 0, "ps_pause");
        cyc(1, 0, 1, 0, 8'd0, 8'd2, 1, 0, "ps_en3");
        cyc(1, 0, 1, 0, 8'd0, 8'd1, 1, 0, "ps_first_dec");
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 0, 8'd0, 8'd1, 1, 0, "ps_hold1");
        cyc(1, 0, 1, 0, 8'd0, AR ? 8'd2 : 8'd0, AR, 1, "ps_tc");
        cyc(1, 0, 1, 0, 8'd0, AR ? 8'd2 : 8'd0, AR, 0, "ps_after_tc");

        // Reset in the middle of a long run.
        cyc(0, 0, 1, 1, 8'd200, 8'd200, 1, 0, "rm_load200");
        for (int i = 1; i <= 10; i++)
            cyc(0, 0, 1, 0, 8'd0, 8'(200 - i), 1, 0, "rm_run");
        cyc(0, 1, 1, 0, 8'd0, 8'd0, 0, 0, "rm_rst");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 0, 8'd0, 8'd0, 0, 0, "rm_idle_no_tc");

        @(negedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
